// File: rtl/sn_chunk_packer_if.sv
// Bus bundle for sn_chunk_packer: narrow beat input with ready, wide chunk output with stall.
// slave is the packer's view; master is the source/sink environment's view.
interface sn_chunk_packer_if #(
  parameter int P_LOG  = 4,
  parameter int IN_LOG = 1,
  parameter int DATW   = 64
);
  // Beat transfer: a beat moves on a rising CLK edge when IN_VALID & IN_READY; IN_LAST is
  // meaningful only with IN_VALID. DOTEN is a one-cycle chunk pulse with no ready; STALL
  // withholds issue and the packer then drops IN_READY until the held chunk leaves.
  logic [(DATW<<IN_LOG)-1:0] IN_DATA;
  logic                      IN_VALID;
  logic                      IN_LAST;
  logic                      IN_READY;
  logic                      STALL;
  logic [(DATW<<P_LOG)-1:0]  DOT;
  logic                      DOTEN;
  logic                      DOT_LAST;
  logic                      DBG_HOLD;

  modport slave (
    input  IN_DATA, IN_VALID, IN_LAST, STALL,
    output IN_READY, DOT, DOTEN, DOT_LAST, DBG_HOLD
  );

  modport master (
    output IN_DATA, IN_VALID, IN_LAST, STALL,
    input  IN_READY, DOT, DOTEN, DOT_LAST, DBG_HOLD
  );
endinterface

// File: rtl/sn_chunk_packer.sv
// Packs 2^IN_LOG-record beats into 2^P_LOG-record chunks for the EVEN_ODD network, padding short tails.
// Optional SN_CHUNK_PACKER_STAT_EN adds CHUNK_CNT / PAD_CNT statistics outputs.
module sn_chunk_packer #(
  parameter int              P_LOG  = 4,
  parameter int              IN_LOG = 1,
  parameter int              DATW   = 64,
  parameter int              KEYW   = 32,
  parameter logic [DATW-1:0] PAD    = {DATW{1'b1}}
) (
  input  logic               CLK,
  input  logic               RST,
  sn_chunk_packer_if.slave   bus
`ifdef SN_CHUNK_PACKER_STAT_EN
  ,
  output logic [31:0]        CHUNK_CNT,
  output logic [31:0]        PAD_CNT
`endif
);

  localparam int ELEMS = 1 << IN_LOG;
  localparam int BW    = DATW << IN_LOG;
  localparam int CHW   = DATW << P_LOG;
  localparam int B     = 1 << (P_LOG - IN_LOG);
  localparam int CW    = (P_LOG > IN_LOG) ? (P_LOG - IN_LOG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(B - 1);
  localparam logic [BW-1:0] PAD_BEAT = {ELEMS{PAD}};

  if (IN_LOG > P_LOG || IN_LOG < 0 || KEYW > DATW) begin : g_bad_cfg
    $error("sn_chunk_packer: illegal parameter combination");
  end

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t          r_state;
  logic [CHW-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_hold_last;
  logic [CHW-1:0]  r_dot;
  logic            r_doten;
  logic            r_dot_last;

  logic            w_ready;
  logic            w_accept;
  logic            w_complete;
  logic [CHW-1:0]  w_merged;

  assign w_ready    = (r_state == ST_ACC) & ~RST;
  assign w_accept   = bus.IN_VALID & w_ready;
  assign w_complete = w_accept & ((r_cnt == LAST_CNT) | bus.IN_LAST);

  // Completed chunk: earlier beats from acc, the current beat at slot cnt, PAD above it.
  for (genvar g = 0; g < B; g++) begin : g_merge
    assign w_merged[g*BW +: BW] = (CW'(g) <  r_cnt) ? r_acc[g*BW +: BW] :
                                  (CW'(g) == r_cnt) ? bus.IN_DATA       : PAD_BEAT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_ACC;
      r_cnt       <= '0;
      r_hold_last <= 1'b0;
      r_dot       <= '0;
      r_doten     <= 1'b0;
      r_dot_last  <= 1'b0;
    end else begin
      r_doten <= 1'b0;
      if (r_state == ST_HOLD) begin
        if (!bus.STALL) begin
          r_dot      <= r_acc;
          r_doten    <= 1'b1;
          r_dot_last <= r_hold_last;
          r_state    <= ST_ACC;
        end
      end else if (w_complete) begin
        r_cnt <= '0;
        if (!bus.STALL) begin
          r_dot      <= w_merged;
          r_doten    <= 1'b1;
          r_dot_last <= bus.IN_LAST;
        end else begin
          r_acc       <= w_merged;
          r_hold_last <= bus.IN_LAST;
          r_state     <= ST_HOLD;
        end
      end else if (w_accept) begin
        r_acc[int'(r_cnt)*BW +: BW] <= bus.IN_DATA;
        r_cnt                       <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.IN_READY = w_ready;
  assign bus.DOT      = r_dot;
  assign bus.DOTEN    = r_doten;
  assign bus.DOT_LAST = r_dot_last;
  assign bus.DBG_HOLD = (r_state == ST_HOLD);

`ifdef SN_CHUNK_PACKER_STAT_EN
  logic [31:0] r_chunk_cnt;
  logic [31:0] r_pad_cnt;
  logic        w_issue;
  logic [31:0] w_pad_slots;

  assign w_issue     = ~bus.STALL & ((r_state == ST_HOLD) | w_complete);
  assign w_pad_slots = (32'(B - 1) - 32'(r_cnt)) << IN_LOG;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chunk_cnt <= '0;
      r_pad_cnt   <= '0;
    end else begin
      if (w_issue)    r_chunk_cnt <= r_chunk_cnt + 32'd1;
      if (w_complete) r_pad_cnt   <= r_pad_cnt + w_pad_slots;
    end
  end

  assign CHUNK_CNT = r_chunk_cnt;
  assign PAD_CNT   = r_pad_cnt;
`endif

endmodule

// File: doc/sn_chunk_packer.md
# sn_chunk_packer

Input-side packer for the `EVEN_ODD` sorting network. It collects a narrow stream of records, `2^IN_LOG` per beat, into full `2^P_LOG`-record vectors and presents each vector for one cycle on `DOT`/`DOTEN`. Those outputs drive the network's `DIN`/`DINEN` directly. A stream that ends on a partial chunk is padded with a sentinel record, so the network always sorts full vectors. `STALL` lets a downstream merge stage or FIFO withhold chunk issue; the packer back-pressures its source with `IN_READY` while a chunk is held.

## Interface
Parameters:
- `P_LOG`, 4: log2 of records per output chunk.
- `IN_LOG`, 1: log2 of records per input beat. Constraint: 0 ≤ `IN_LOG` ≤ `P_LOG`.
- `DATW`, 64: record width. The key is bits [`KEYW`-1:0] of each record.
- `KEYW`, 32: key width; informational only, the packer does not inspect keys.
- `PAD`, {`DATW`{1'b1}}: sentinel record written into unfilled slots.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-high.
- `IN_DATA`  in  `DATW<<IN_LOG`  beat; record e occupies [`DATW`*(e+1)-1:`DATW`*e].
- `IN_VALID`  in  1  beat valid.
- `IN_LAST`  in  1  beat is the final beat of the stream; qualified by `IN_VALID`.
- `IN_READY`  out  1  packer accepts a beat this cycle.
- `STALL`  in  1  downstream forbids chunk issue.
- `DOT`  out  `DATW<<P_LOG`  chunk; connects to `EVEN_ODD.DIN`.
- `DOTEN`  out  1  one-cycle chunk-valid pulse; connects to `EVEN_ODD.DINEN`.
- `DOT_LAST`  out  1  chunk is the final chunk of the stream; valid while `DOTEN`=1.

## Operation
- B = 2^(`P_LOG`-`IN_LOG`) beats per chunk.
- Registers: `acc` (one chunk), beat counter `cnt` [0..B-1], `hold`, `hold_last`, and output registers `DOT`, `DOTEN`, `DOT_LAST`.
- `IN_READY` = !`hold` & !`RST`. A beat is accepted when `IN_VALID` & `IN_READY`.
- Slot mapping: beat n of a chunk fills records n·2^`IN_LOG` through (n+1)·2^`IN_LOG`-1, with the earliest beat in the lowest slots.
- Complete = accepted & (`cnt`==B-1 | `IN_LAST`). The completed value is `acc` merged with the current beat in slot `cnt`; every slot above the current beat is set to `PAD`.
- States are ACC (`hold`=0) and HOLD (`hold`=1). Per cycle, in priority order:
  - HOLD & !`STALL`: `DOT`←`acc`, `DOTEN`←1, `DOT_LAST`←`hold_last`, `hold`←0 (→ACC).
  - Complete & !`STALL`: `DOT`←completed value, `DOTEN`←1, `DOT_LAST`←`IN_LAST`, `cnt`←0.
  - Complete & `STALL`: `acc`←completed value, `hold`←1, `hold_last`←`IN_LAST`, `cnt`←0, `DOTEN`←0 (→HOLD).
  - Accepted, not complete: write the beat into slot `cnt`, `cnt`←`cnt`+1, `DOTEN`←0.
  - Otherwise: `DOTEN`←0.
- `DOT` and `DOT_LAST` hold their last values while `DOTEN`=0.
- `IN_LAST` with `cnt`==B-1 produces no padding.
- Every beat is full (2^`IN_LOG` valid records). Streams with zero records are not supported.
- A stream ends at its `IN_LAST` beat; the next accepted beat starts a new chunk at slot 0.

## Timing
- Reset: `DOTEN`=0, `DOT_LAST`=0, `DOT`=0, `cnt`=0, `hold`=0. `IN_READY`=0 while `RST`=1 and 1 on the first cycle after. `acc` is not reset.
- Reset mid-chunk discards the partial chunk and any held chunk.
- Latency: completing beat accepted at edge t, `STALL`=0 → `DOTEN`=1 during cycle t+1.
- Throughput: one chunk per B cycles. With `IN_LOG`=`P_LOG`, one chunk per cycle and `DOTEN` can stay high continuously.
- `STALL` is sampled in the same cycle as completion, and in every cycle while in HOLD.
- HOLD with `STALL` falling at cycle s → `DOTEN`=1 at s+1 and `IN_READY`=1 at s+1.
- No beat is accepted while in HOLD; the HOLD→issue transition and a new accept never share a cycle.
- `STALL` does not gate accepts of non-completing beats.

## Configuration
- `SN_CHUNK_PACKER_STAT_EN` defined: adds outputs `CHUNK_CNT` [31:0] and `PAD_CNT` [31:0].
  - `CHUNK_CNT` +1 per `DOTEN` pulse.
  - `PAD_CNT` += number of `PAD` slots inserted in each completed chunk, counted at completion.
  - Both reset to 0 and wrap modulo 2^32.
- `SN_CHUNK_PACKER_STAT_EN` undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
Default parameters (B=8) unless noted.
- 8 consecutive beats of records 0..15, `STALL`=0 → one `DOTEN` pulse one cycle after beat 8; record i = i; `DOT_LAST`=0; `CHUNK_CNT`=1.
- 3 beats (records 0..5), `IN_LAST` on beat 3 → `DOTEN` next cycle; slots 6..15 = `PAD`; `DOT_LAST`=1; `PAD_CNT`=10.
- `STALL`=1 held 4 cycles from before beat 8 → `DOTEN`=0 and `IN_READY`=0 while stalled. `STALL` low at cycle s → `DOTEN`=1 at s+1; chunk intact; no beat lost.
- `IN_LOG`=`P_LOG`=4, 5 back-to-back beats with `IN_LAST` on beat 5 → `DOTEN` high for 5 consecutive cycles; `DOT_LAST` set only on the 5th.
- `RST` pulsed after 5 beats, then 8 fresh beats of records 100..115 → output record i = 100+i, with no residue from before reset.
- `IN_VALID` toggling every other cycle over 8 beats → a single correct chunk one cycle after the last accepted beat.
